// File: rtl/mux_arbiter_pkg.sv
// rtl/mux_arbiter_pkg.sv - shared state enumeration and select encodings for mux_arbiter
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_arbiter_mux2.sv
// rtl/mux_arbiter_mux2.sv - gate-level one-bit 2:1 mux, y = s ? b : a
module mux2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_s,
  output logic o_y
);

  wire w_s_n;
  wire w_a_term;
  wire w_b_term;
  wire w_y;

  not u_inv  (w_s_n, i_s);
  and u_and_a(w_a_term, i_a, w_s_n);
  and u_and_b(w_b_term, i_b, i_s);
  or  u_or   (w_y, w_a_term, w_b_term);

  assign o_y = w_y;

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester round-robin arbiter with registered muxed output
// MUX_ARBITER_HOLD_LIMIT_EN: defined builds the hold counter that forces handoff after MAX_HOLD cycles.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] a_data,
  input  logic [W-1:0] b_data,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         sel,
  output logic [W-1:0] y_data,
  output logic         y_valid
);

  state_t         r_state;
  state_t         w_next;
  logic           r_last_b;
  logic           r_gnt_a;
  logic           r_gnt_b;
  logic           r_sel;
  logic [W-1:0]   r_y_data;
  logic           r_y_valid;
  logic           w_hold_hit;
  logic [W-1:0]   w_mux;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_arbiter: MAX_HOLD must be within 1..255");
  end

`ifdef MUX_ARBITER_HOLD_LIMIT_EN
  localparam logic [8:0] HOLD_LIM = 9'(MAX_HOLD);
  logic [7:0] r_hold;

  // r_hold counts ownership cycles already completed, so the current cycle is number r_hold+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 8'd0;
    end else if (w_next != r_state) begin
      r_hold <= 8'd0;
    end else if (r_state != IDLE && {1'b0, r_hold} != HOLD_LIM) begin
      r_hold <= r_hold + 8'd1;
    end
  end

  assign w_hold_hit = (r_state != IDLE) && (({1'b0, r_hold} + 9'd1) >= HOLD_LIM);
`else
  assign w_hold_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_a && req_b) w_next = r_last_b ? OWN_A : OWN_B;
        else if (req_a)     w_next = OWN_A;
        else if (req_b)     w_next = OWN_B;
      end
      OWN_A: begin
        if (!req_a)                 w_next = req_b ? OWN_B : IDLE;
        else if (req_b && w_hold_hit) w_next = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                 w_next = req_a ? OWN_A : IDLE;
        else if (req_a && w_hold_hit) w_next = OWN_A;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_sel    <= SEL_A;
      r_last_b <= 1'b1;
    end else begin
      r_state <= w_next;
      r_gnt_a <= (w_next == OWN_A);
      r_gnt_b <= (w_next == OWN_B);
      if (w_next == OWN_A) begin
        r_sel    <= SEL_A;
        r_last_b <= 1'b0;
      end else if (w_next == OWN_B) begin
        r_sel    <= SEL_B;
        r_last_b <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    mux2 u_mux (
      .i_a(a_data[i]),
      .i_b(b_data[i]),
      .i_s(r_sel),
      .o_y(w_mux[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_data  <= '0;
      r_y_valid <= 1'b0;
    end else begin
      if (r_gnt_a || r_gnt_b) r_y_data <= w_mux;
      r_y_valid <= r_gnt_a | r_gnt_b;
    end
  end

  assign gnt_a   = r_gnt_a;
  assign gnt_b   = r_gnt_b;
  assign sel     = r_sel;
  assign y_data  = r_y_data;
  assign y_valid = r_y_valid;

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter W, default 8, data width of each requester port and of the output.
REQ-002 Parameter MAX_HOLD, default 15, maximum consecutive grant cycles before forced handoff (range 1..255).
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_a  input  1  requester A requests the shared path; held high for as long as it wants it.
REQ-006 req_b  input  1  requester B requests the shared path; held high for as long as it wants it.
REQ-007 a_data  input  W  requester A data.
REQ-008 b_data  input  W  requester B data.
REQ-009 gnt_a  output  1  A owns the path this cycle.
REQ-010 gnt_b  output  1  B owns the path this cycle.
REQ-011 sel  output  1  mux select, 0 = A, 1 = B.
REQ-012 y_data  output  W  registered muxed data.
REQ-013 y_valid  output  1  y_data holds data from a granted cycle.

Function
REQ-014 The FSM SHALL have three states: IDLE, OWN_A, OWN_B; gnt_a = (state==OWN_A), gnt_b = (state==OWN_B); gnt_a and gnt_b SHALL never be high together.
REQ-015 From IDLE: only req_a -> OWN_A; only req_b -> OWN_B; both -> the requester not served last (pointer last_b); none -> stay IDLE.
REQ-016 From OWN_A: req_a low and req_b high -> OWN_B next cycle (zero idle cycles); req_a low and req_b low -> IDLE; req_a high -> stay, except as REQ-019; same rules mirrored for OWN_B.
REQ-017 last_b SHALL update on every entry to OWN_A (cleared) or OWN_B (set).
REQ-018 sel SHALL be 0 in OWN_A, 1 in OWN_B, and hold its previous value in IDLE.
REQ-019 Hold counter: cleared on entry to any OWN state, increments each cycle in it, saturates at MAX_HOLD; on the cycle it equals MAX_HOLD with the other request high, the next state SHALL be the other OWN state.
REQ-020 y_data SHALL register (sel ? b_data : a_data) every cycle a grant is high, holding its value otherwise; y_valid SHALL register (gnt_a | gnt_b); latency request-to-grant 1 cycle, grant-to-y_valid 1 cycle.
REQ-021 A request dropped and reasserted while owning SHALL not extend ownership: drop always releases per REQ-016.

Reset
REQ-022 On rst_n low, immediately: state IDLE, gnt_a 0, gnt_b 0, sel 0, y_data 0, y_valid 0, last_b 1 (A wins first tie), hold counter 0.
REQ-023 Reset asserted mid-grant SHALL drop the grant at once; after deassertion arbitration restarts from IDLE on the next rising edge.

Configuration
REQ-024 Macro MUX_ARBITER_HOLD_LIMIT_EN: defined -> REQ-019 active; undefined -> no hold counter is built, MAX_HOLD is ignored, and ownership lasts until the owner drops its request.

Structure
REQ-025 A shared package SHALL hold the state enumeration (IDLE, OWN_A, OWN_B) and the select encodings SEL_A=0, SEL_B=1.
REQ-026 The datapath SHALL instantiate the existing gate-level mux2 once per bit (W instances, S tied to sel); no other sub-module.

Verification
REQ-027 Reset, then req_a=1 only, a_data=8'h3C -> gnt_a=1 after 1 cycle, sel=0, y_data=8'h3C with y_valid=1 one cycle later.
REQ-028 From reset, req_a=req_b=1 same edge -> OWN_A first; A drops -> OWN_B on the next cycle with no IDLE cycle, sel=1.
REQ-029 Both idle after B served, then both request together -> A granted (round-robin tie break).
REQ-030 HOLD_LIMIT_EN defined, MAX_HOLD=4, req_a held, req_b raised on cycle 1 -> gnt_b rises exactly 4 cycles after gnt_a rose; undefined -> gnt_a held for 20 cycles.
REQ-031 rst_n pulsed low during OWN_B -> gnt_b, y_valid, sel go 0 without a clock edge; after release with req_b=1 -> OWN_B again 1 cycle later.
REQ-032 Every test SHALL check each cycle that gnt_a & gnt_b is never 1.
